lc3b_mem_responder: RTL and testbench



---
 rtl/lc3b_types.sv | 10 +
 rtl/lc3b_mem_array.sv | 30 +++
 rtl/lc3b_mem_responder.sv | 132 +++++++++++++
 tb/tb_lc3b_mem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the CPU memory port and the memory responder.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    // Upper bound on the responder latency; sets the width of its countdown register.
    localparam int LC3B_MEM_MAX_LATENCY = 15;

endpackage

// File: rtl/lc3b_mem_array.sv
// Single-port DEPTH x 16 RAM: synchronous byte-lane write, combinational read.
// Each byte lane is its own array so a lane write never touches the other half.
module lc3b_mem_array
    import lc3b_types::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  lc3b_mem_wmask            we_i,
    input  lc3b_word                 wdata_i,
    output lc3b_word                 rdata_o
);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];

            // Lane write: bit gi of the write mask owns bits [8*gi+7 : 8*gi].
            always_ff @(posedge clk) begin
                if (we_i[gi]) begin
                    mem_q[addr_i] <= wdata_i[gi*8 +: 8];
                end
            end

            assign rdata_o[gi*8 +: 8] = mem_q[addr_i];
        end
    endgenerate

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: accepts mem_read/mem_write, completes them after LATENCY
// cycles with a one-cycle mem_resp, backed by lc3b_mem_array.
// Optional feature macro: LC3B_MEM_ADDR_CHECK_EN (out-of-range word index -> mem_error,
// write suppressed, read data 0). Without it the word index wraps modulo DEPTH.
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    input  lc3b_mem_wmask mem_byte_enable,
    output lc3b_word      mem_rdata,
    output logic          mem_resp,
    output logic          mem_error
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [14:0]   idx_q;
    lc3b_word      wdata_q;
    lc3b_mem_wmask be_q;
    logic          write_q;
    lc3b_word      rdata_q;
    logic          resp_q;
    logic          error_q;

    logic          req;
    logic [14:0]   acc_idx;
    lc3b_word      acc_wdata;
    lc3b_mem_wmask acc_be;
    logic          acc_write;
    logic          enter_resp;
    logic          in_range;
    lc3b_mem_wmask arr_we;
    lc3b_word      arr_rdata;

    // Select the live request in IDLE (needed when LATENCY is 1) or the latched one
    // otherwise, and flag the cycle whose closing edge enters RESP.
    always_comb begin
        req        = mem_read | mem_write;
        enter_resp = 1'b0;
        if (state_q == IDLE) begin
            acc_idx    = mem_address[15:1];
            acc_wdata  = mem_wdata;
            acc_be     = mem_byte_enable;
            acc_write  = mem_write;
            enter_resp = req && (LATENCY == 1);
        end else begin
            acc_idx    = idx_q;
            acc_wdata  = wdata_q;
            acc_be     = be_q;
            acc_write  = write_q;
            enter_resp = (state_q == BUSY) && (cnt_q == 4'd1);
        end
    end

`ifdef LC3B_MEM_ADDR_CHECK_EN
    assign in_range = ({1'b0, acc_idx} < 16'(DEPTH));
`else
    assign in_range = 1'b1;
`endif

    // Reset gates the write so an access aborted by reset never commits.
    assign arr_we = (enter_resp && acc_write && in_range && !rst) ? acc_be : 2'b00;

    lc3b_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk     (clk),
        .addr_i  (acc_idx[AW-1:0]),
        .we_i    (arr_we),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

    // Access FSM with countdown, request latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            rdata_q <= 16'h0000;
            resp_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            resp_q  <= enter_resp;
            error_q <= enter_resp && !in_range;
            if (enter_resp && !acc_write) begin
                rdata_q <= in_range ? arr_rdata : 16'h0000;
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        idx_q   <= mem_address[15:1];
                        wdata_q <= mem_wdata;
                        be_q    <= mem_byte_enable;
                        write_q <= mem_write;
                        cnt_q   <= CNT_LOAD;
                        state_q <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = resp_q;
    assign mem_error = error_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: directed scenarios with literal
// expectations, then randomized accesses checked each cycle against a model.
module tb_lc3b_mem_responder;
    import lc3b_types::*;

    localparam int L = 3;
    localparam int D = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_address = '0;
    logic [15:0] mem_wdata = '0;
    logic [1:0]  mem_byte_enable = '0;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        mem_error;

    lc3b_mem_responder #(.LATENCY(L), .DEPTH(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .mem_error       (mem_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Reference model: word store with per-byte "known" flags, plus one pending access.
    logic [15:0] mdl_mem [D];
    bit   [1:0]  mdl_known [D];
    bit          pend_valid = 1'b0;
    int          pend_cycle;
    bit          pend_write;
    int          pend_idx;
    logic [15:0] pend_wdata;
    logic [1:0]  pend_be;
    logic [15:0] exp_rdata = 16'h0000;
    bit          rd_known = 1'b1;
    logic        exp_resp;
    logic        exp_err;
    int          w;

    function automatic bit in_rng(int idx);
`ifdef LC3B_MEM_ADDR_CHECK_EN
        return idx < D;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Per-cycle compare: response lands exactly LATENCY cycles after the request rose.
    always @(negedge clk) begin
        exp_resp = 1'b0;
        exp_err  = 1'b0;
        if (rst) begin
            exp_rdata = 16'h0000;
            rd_known  = 1'b1;
        end else if (pend_valid && cyc == pend_cycle) begin
            w        = pend_idx % D;
            exp_resp = 1'b1;
            exp_err  = !in_rng(pend_idx);
            if (pend_write) begin
                if (in_rng(pend_idx)) begin
                    for (int b = 0; b < 2; b++) begin
                        if (pend_be[b]) begin
                            mdl_mem[w][b*8 +: 8] = pend_wdata[b*8 +: 8];
                            mdl_known[w][b] = 1'b1;
                        end
                    end
                end
            end else if (in_rng(pend_idx)) begin
                exp_rdata = mdl_mem[w];
                rd_known  = (mdl_known[w] == 2'b11);
            end else begin
                exp_rdata = 16'h0000;
                rd_known  = 1'b1;
            end
            pend_valid = 1'b0;
        end
        check("resp", {15'd0, mem_resp}, {15'd0, exp_resp});
        check("error", {15'd0, mem_error}, {15'd0, exp_err});
        if (rd_known) check("rdata", mem_rdata, exp_rdata);
    end

    // Raise a request in the current cycle, keep it for 'hold' cycles, return in the
    // IDLE cycle after the response so a following call is back-to-back.
    task automatic access(bit rd, bit wr, logic [15:0] addr, logic [15:0] wd,
                          logic [1:0] be, int hold);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wd;
        mem_byte_enable = be;
        pend_write = wr;
        pend_idx   = int'(addr[15:1]);
        pend_wdata = wd;
        pend_be    = be;
        pend_cycle = cyc + L;
        pend_valid = 1'b1;
        for (int i = 1; i <= L + 1; i++) begin
            @(posedge clk);
            #1;
            if (i == hold) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        end
    endtask

    task automatic wr16(logic [15:0] addr, logic [15:0] wd, logic [1:0] be);
        access(1'b0, 1'b1, addr, wd, be, L + 1);
    endtask

    task automatic rd16(logic [15:0] addr);
        access(1'b1, 1'b0, addr, 16'h0000, 2'b00, L + 1);
    endtask

    initial begin
        int op, idx, hold, gap;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_rdata", mem_rdata, 16'h0000);
        check("reset_resp", {15'd0, mem_resp}, 16'd0);

        wr16(16'h0010, 16'hC0DE, 2'b11);
        rd16(16'h0010);
        check("preload_read", mem_rdata, 16'hC0DE);

        wr16(16'h0020, 16'hBEEF, 2'b11);
        rd16(16'h0020);
        check("full_write", mem_rdata, 16'hBEEF);
        wr16(16'h0020, 16'h1234, 2'b01);
        rd16(16'h0020);
        check("lane_low", mem_rdata, 16'hBE34);
        wr16(16'h0020, 16'h5600, 2'b10);
        rd16(16'h0020);
        check("lane_high", mem_rdata, 16'h5634);
        wr16(16'h0020, 16'hFFFF, 2'b00);
        rd16(16'h0021);
        check("mask_none", mem_rdata, 16'h5634);

        wr16(16'h0040, 16'h5555, 2'b11);
        access(1'b1, 1'b1, 16'h0040, 16'hAAAA, 2'b11, L + 1);
        check("both_keeps_rdata", mem_rdata, 16'h5634);
        rd16(16'h0040);
        check("both_is_write", mem_rdata, 16'hAAAA);

        access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1);
        check("dropped_read", mem_rdata, 16'hC0DE);

        // Reset while a write of 0x7777 is in BUSY.
        wr16(16'h0030, 16'h1111, 2'b11);
        mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'h7777; mem_byte_enable = 2'b11;
        @(posedge clk); #1;
        mem_write = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rdata", mem_rdata, 16'h0000);
        repeat (L + 1) begin @(posedge clk); #1; end
        rd16(16'h0030);
        check("abort_no_write", mem_rdata, 16'h1111);

        wr16(16'h0000, 16'h0F0F, 2'b11);
        wr16(16'h0200, 16'h9999, 2'b11);
        rd16(16'h0000);
`ifdef LC3B_MEM_ADDR_CHECK_EN
        check("oor_word0", mem_rdata, 16'h0F0F);
`else
        check("wrap_word0", mem_rdata, 16'h9999);
`endif

        // Random phase over words 0..15 and their aliases at index 256..271.
        for (int i = 0; i < 16; i++) wr16(16'(i * 2), 16'($urandom), 2'b11);
        for (int n = 0; n < 300; n++) begin
            op   = $urandom_range(2, 0);
            idx  = $urandom_range(15, 0) + (($urandom_range(3, 0) == 0) ? 256 : 0);
            hold = $urandom_range(L + 1, 1);
            access(op != 1, op != 0, 16'((idx << 1) | $urandom_range(1, 0)),
                   16'($urandom), 2'($urandom_range(3, 0)), hold);
            gap = $urandom_range(2, 0);
            repeat (gap) begin @(posedge clk); #1; end
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
